// File: rtl/vblank_update_scheduler.sv
// Frame update scheduler: detects the start of vertical blanking and hands a shared
// update window to each enabled client in turn over a go/done handshake.
module vblank_update_scheduler #(
  parameter int NUM_CLIENTS = 4,
  parameter int V_ACTIVE    = 480,
  parameter int FCNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [9:0]             v_idx,
  input  logic [9:0]             h_idx,
  input  logic [NUM_CLIENTS-1:0] client_en,
  input  logic [NUM_CLIENTS-1:0] done,
  output logic [NUM_CLIENTS-1:0] go,
  output logic                   frame_tick,
  output logic                   frame_done,
  output logic                   busy,
  output logic                   overrun,
  output logic [7:0]             overrun_cnt,
  output logic [FCNT_W-1:0]      frame_cnt
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [NUM_CLIENTS-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]       cur_q, cur_d;
  logic [IDX_W-1:0]       sel_idx;
  logic [NUM_CLIENTS-1:0] go_d;
  logic                   frame_tick_d, frame_done_d, overrun_d, busy_d;
  logic [7:0]             overrun_cnt_d;
  logic [FCNT_W-1:0]      frame_cnt_d;
  logic                   in_vb, in_vb_q, vb_start;
  logic                   grant_done, abort;

  // Detection uses the line counter only; the column is deliberately ignored.
  logic unused_h;
  assign unused_h = ^h_idx;

  assign in_vb    = (v_idx >= 10'(V_ACTIVE));
  assign vb_start = in_vb & ~in_vb_q;

  // Only the bit of the currently granted client can complete the handshake.
  assign grant_done = |(go & done);

  always_comb begin
    sel_idx = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = IDX_W'(i);
    end
  end

  // A completion in the same cycle as active video resuming is honoured first;
  // the abort then only happens if work remains when SCAN is re-entered.
  always_comb begin
    abort = 1'b0;
    if (!in_vb) begin
      if (state_q == SCAN && pending_q != '0) abort = 1'b1;
      if (state_q == WAIT && !grant_done)     abort = 1'b1;
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    cur_d         = cur_q;
    go_d          = go;
    frame_tick_d  = 1'b0;
    frame_done_d  = 1'b0;
    overrun_d     = 1'b0;
    overrun_cnt_d = overrun_cnt;
    frame_cnt_d   = frame_cnt;

    unique case (state_q)
      IDLE: begin
        if (vb_start) begin
          state_d      = SCAN;
          frame_tick_d = 1'b1;
          frame_cnt_d  = frame_cnt + FCNT_W'(1);
          pending_d    = client_en;
        end
      end
      SCAN: begin
        if (pending_q == '0) begin
          state_d = DONE;
        end else if (!abort) begin
          cur_d   = sel_idx;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (grant_done) begin
          go_d             = '0;
          pending_d[cur_q] = 1'b0;
          state_d          = SCAN;
        end else if (!abort && go == '0) begin
          go_d = NUM_CLIENTS'(1) << cur_q;
        end
      end
      DONE: begin
        frame_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d   = IDLE;
      go_d      = '0;
      pending_d = '0;
      overrun_d = 1'b1;
      if (overrun_cnt != 8'hFF) overrun_cnt_d = overrun_cnt + 8'd1;
    end

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      cur_q       <= '0;
      in_vb_q     <= 1'b1;
      go          <= '0;
      frame_tick  <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
      frame_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      cur_q       <= cur_d;
      in_vb_q     <= in_vb;
      go          <= go_d;
      frame_tick  <= frame_tick_d;
      frame_done  <= frame_done_d;
      busy        <= busy_d;
      overrun     <= overrun_d;
      overrun_cnt <= overrun_cnt_d;
      frame_cnt   <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Directed bench for vblank_update_scheduler: frames with scripted client responses,
// aborts, overrun saturation and asynchronous reset.
module tb_vblank_update_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  v_idx;
  logic [9:0]  h_idx;
  logic [3:0]  client_en;
  logic [3:0]  done;
  logic [3:0]  go;
  logic        frame_tick;
  logic        frame_done;
  logic        busy;
  logic        overrun;
  logic [7:0]  overrun_cnt;
  logic [15:0] frame_cnt;

  int n_vec = 0;
  int n_miscmp = 0;

  // Per-frame observations, filled by serve().
  logic [3:0] grants[$];
  int         n_grants, tick_at, first_go_at, fd_n, fd_at, ov_n, ov_at, onehot_err, busy_at1;
  logic [3:0] go_at_ov;

  vblank_update_scheduler #(.NUM_CLIENTS(4), .V_ACTIVE(480), .FCNT_W(16)) dut (
    .clk(clk), .rst(rst), .v_idx(v_idx), .h_idx(h_idx), .client_en(client_en),
    .done(done), .go(go), .frame_tick(frame_tick), .frame_done(frame_done),
    .busy(busy), .overrun(overrun), .overrun_cnt(overrun_cnt), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) h_idx <= h_idx + 10'd1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leave vblank so the next 480 is seen as a fresh vblank start.
  task automatic leave_vb();
    v_idx = 10'd479;
    done  = '0;
    step();
    step();
  endtask

  // Starts a frame (v_idx -> 480 in cycle T) and observes T+1..T+max_cyc. Each granted
  // client pulses done lat cycles after its go rises, unless it is in stuck. At cycle
  // drop_at, v_idx returns to 0 for the rest of the window.
  task automatic serve(input logic [3:0] en, input int lat, input logic [3:0] stuck,
                       input int drop_at, input int max_cyc);
    logic [3:0] prev_go;
    int g;
    grants.delete();
    tick_at = -1; first_go_at = -1; fd_n = 0; fd_at = -1; ov_n = 0; ov_at = -1;
    onehot_err = 0; busy_at1 = 0; go_at_ov = 4'hF; prev_go = '0; g = 0;
    v_idx = 10'd480; client_en = en; done = '0;
    for (int c = 1; c <= max_cyc; c++) begin
      step();
      if (c == 1) busy_at1 = int'(busy);
      if (frame_tick) tick_at = c;
      if (frame_done) begin fd_n++; fd_at = c; end
      if (overrun) begin ov_n++; ov_at = c; go_at_ov = go; end
      if (!$onehot0(go)) onehot_err++;
      if (go != '0 && go != prev_go) begin
        grants.push_back(go);
        g = c;
        if (first_go_at < 0) first_go_at = c;
      end
      prev_go = go;
      done = '0;
      if (go != '0 && (c - g) == lat && (go & stuck) == '0) done = go;
      if (c == drop_at) v_idx = 10'd0;
    end
    done = '0;
    n_grants = grants.size();
    while (grants.size() < 4) grants.push_back('0);
  endtask

  initial begin
    rst = 1'b1; v_idx = 10'd500; h_idx = '0; client_en = '0; done = '0;
    step();
    step();
    check("rst_go", go, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_overrun_cnt", overrun_cnt, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_tick_after_rst", frame_tick, 0);
    end

    // Frame 1: clients 0,1,3 enabled, done 3 cycles after go.
    leave_vb();
    serve(4'b1011, 3, 4'b0000, -1, 24);
    check("A_tick_at", tick_at, 1);
    check("A_busy_at_tick", busy_at1, 1);
    check("A_frame_cnt", frame_cnt, 1);
    check("A_first_go_at", first_go_at, 3);
    check("A_n_grants", n_grants, 3);
    check("A_grant0", grants[0], 4'b0001);
    check("A_grant1", grants[1], 4'b0010);
    check("A_grant2", grants[2], 4'b1000);
    check("A_onehot", onehot_err, 0);
    check("A_fd_n", fd_n, 1);
    check("A_fd_at", fd_at, 21);
    check("A_overrun_cnt", overrun_cnt, 0);
    check("A_busy_end", busy, 0);

    // Empty mask: frame_done two cycles after frame_tick, no grants.
    leave_vb();
    serve(4'b0000, 3, 4'b0000, -1, 6);
    check("B_tick_at", tick_at, 1);
    check("B_fd_at", fd_at, 3);
    check("B_fd_n", fd_n, 1);
    check("B_n_grants", n_grants, 0);

    // Client 1 stalls; active video resumes while it holds go.
    leave_vb();
    serve(4'b1111, 3, 4'b0010, 14, 17);
    check("C_n_grants", n_grants, 2);
    check("C_grant1", grants[1], 4'b0010);
    check("C_ov_n", ov_n, 1);
    check("C_ov_at", ov_at, 15);
    check("C_go_at_ov", go_at_ov, 0);
    check("C_fd_n", fd_n, 0);
    check("C_overrun_cnt", overrun_cnt, 1);
    check("C_busy_end", busy, 0);

    // Next frame restarts at client 0; done 2 cycles after go.
    serve(4'b1111, 2, 4'b0000, -1, 26);
    check("D_first_go_at", first_go_at, 3);
    check("D_grant0", grants[0], 4'b0001);
    check("D_grant3", grants[3], 4'b1000);
    check("D_fd_at", fd_at, 23);
    check("D_ov_n", ov_n, 0);

    // Last client's done coincides with v_idx -> 0: frame completes normally.
    leave_vb();
    serve(4'b1000, 3, 4'b0000, 6, 11);
    check("E_grant0", grants[0], 4'b1000);
    check("E_fd_n", fd_n, 1);
    check("E_fd_at", fd_at, 9);
    check("E_ov_n", ov_n, 0);
    check("E_overrun_cnt", overrun_cnt, 1);

    // Same, but a client remains pending: abort follows the completion.
    serve(4'b1001, 3, 4'b0000, 6, 11);
    check("E2_ov_at", ov_at, 8);
    check("E2_fd_n", fd_n, 0);
    check("E2_onehot", onehot_err, 0);
    check("E2_overrun_cnt", overrun_cnt, 2);

    // 300 more forced overruns: the count saturates at 255.
    for (int k = 1; k <= 300; k++) begin
      v_idx = 10'd480; client_en = 4'b0001;
      repeat (4) step();
      v_idx = 10'd0;
      repeat (3) step();
      if (k == 100) check("F_overrun_cnt_102", overrun_cnt, 102);
      if (k == 253) check("F_overrun_cnt_sat", overrun_cnt, 255);
    end
    check("F_overrun_cnt_hold", overrun_cnt, 255);
    check("F_frame_cnt", frame_cnt, 306);

    // Asynchronous reset in the middle of a grant.
    leave_vb();
    v_idx = 10'd480; client_en = 4'b0001;
    repeat (4) step();
    check("G_go_before_rst", go, 4'b0001);
    #2 rst = 1'b1;
    #1;
    check("G_rst_go", go, 0);
    check("G_rst_busy", busy, 0);
    check("G_rst_frame_cnt", frame_cnt, 0);
    check("G_rst_overrun_cnt", overrun_cnt, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      done = 4'b1111;
      step();
      check("G_busy_after_done", busy, 0);
      check("G_go_after_done", go, 0);
      check("G_tick_after_done", frame_tick, 0);
    end
    done = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
